led_pattern_ctrl: RTL and testbench
===================================

// Module: led_pattern_ctrl
// PURPOSE
//  Sequencer for the 16-bit board LED bank. Selects a pattern mode (rotate left,
//  rotate right, bounce, blink), paces steps with a prescaled tick, and supports
//  free-run or paused single-step operation from a debounced push button.
//  Sits between the board switches/buttons and the LED pins.
// PARAMETERS
//  TICK_DIV    5000000  clk cycles per base tick (cnt counts 0..TICK_DIV-1)
//  DEB_CYCLES  1000000  cycles step_btn must be stable before its level is accepted
//  LED_W       16       LED bank width (>=4)
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst_n        in   1      asynchronous active-low reset
//  mode         in   2      00 rot-left, 01 rot-right, 10 bounce, 11 blink (async)
//  run          in   1      1 free-run, 0 pause (async)
//  speed        in   2      one step per 2^speed base ticks
//  step_btn     in   1      raw push button, active-high, bouncy (async)
//  led          out  LED_W  LED pattern
//  cur_mode     out  2      mode currently applied
//  running      out  1      1 while in RUN state
//  step_strobe  out  1      1-cycle pulse on every cycle led advances
// BEHAVIOUR
//  Reset (async): led=0x0001, cur_mode=00, dir=L, state=PAUSE,
//   running=0, step_strobe=0, cnt=0, sub=0, syncs and debouncer cleared to 0.
//  Sync: mode, run, step_btn each pass through 2 flops -> mode_s, run_s, btn_s.
//   speed is static config (no sync needed).
//  Debounce: btn_s differs from deb level for DEB_CYCLES consecutive cycles ->
//   deb takes btn_s. Any earlier reversal restarts the count. A 0->1 edge of deb
//   gives a 1-cycle step_req.
//  Prescaler (RUN only): cnt wraps at TICK_DIV-1 with tick=1 on that cycle.
//   On tick: if sub >= (1<<speed)-1 then sub<=0 and ADVANCE, else sub<=sub+1.
//   Use >= so that lowering speed mid-count advances on the next tick.
//  States: PAUSE, RUN.
//   PAUSE->RUN when run_s=1. RUN->PAUSE when run_s=0.
//   Entering or while in PAUSE: cnt=0, sub=0, so a resume waits a full period.
//   PAUSE: step_req -> ADVANCE on the next edge. RUN: step_req ignored.
//  Mode change (highest priority, checked in either state): on any cycle with
//   mode_s!=cur_mode, the edge sets cur_mode<=mode_s, dir<=L, cnt<=0, sub<=0, and
//   led<=seed (00:0x0001, 01:0x8000, 10:0x0001, 11:0x0000).
//   No ADVANCE that cycle, step_strobe=0. A coincident tick or step_req is dropped.
//   The state transition for run_s still applies on that same edge.
//  ADVANCE (step_strobe=1 in the same cycle led updates):
//   00: led<={led[W-2:0],led[W-1]}. 01: led<={led[0],led[W-1:1]}.
//   10: if dir=L, led<=led<<1, and dir<=R if led[W-2].
//       if dir=R, led<=led>>1, and dir<=L if led[1].
//       Sequence 0x0001..0x8000..0x0001, period 2*(W-1) steps.
//   11: led<=~led.
//  Latency: input change -> effect 2 cycles (sync) + 1 edge. The button adds
//   DEB_CYCLES on top.
//  running = (state==RUN), registered.
//  Reset mid-operation forces reset values immediately. No step is pending after
//   rst_n releases.
// TESTING (TICK_DIV=4, DEB_CYCLES=3)
//  1 run=1, mode=00, speed=0 -> led 0x0001->0x0002 every 4 cycles, step_strobe
//    each step, 0x8000->0x0001 wrap.
//  2 mode=10, run=1 -> 0x4000,0x8000,0x4000 ... 0x0002,0x0001,0x0002.
//    Period 30 steps, no double-hold at ends.
//  3 speed=3 -> steps every 32 cycles. Switch speed to 0 at sub=5 -> advance on
//    the next tick.
//  4 run=0: a 2-cycle step_btn glitch -> no step. A 6-cycle press -> exactly one
//    step and one step_strobe. Same press with run=1 -> no extra step.
//  5 mode 00->01 timed so mode_s changes on a tick cycle -> led=0x8000,
//    step_strobe=0, next step 4 cycles later gives 0x4000.
//  6 rst_n low mid-run, asynchronous to clk -> led=0x0001 and running=0 at once.
//    After release with run=1, running=1 within 3 cycles.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - LED bank pattern sequencer with prescaled stepping and debounced single-step
// Rotate/bounce/blink patterns, free-run or paused single-step from a push button.
module led_pattern_ctrl #(
    parameter int TICK_DIV   = 5000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             run,
    input  logic [1:0]       speed,
    input  logic             step_btn,
    output logic [LED_W-1:0] led,
    output logic [1:0]       cur_mode,
    output logic             running,
    output logic             step_strobe
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic {PAUSE, RUN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_s1_q, mode_s_q;
    logic             run_s1_q, run_s_q;
    logic             btn_s1_q, btn_s_q;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             step_req_q, step_req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sub_q, sub_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             dir_q, dir_d;  // 0 = moving left (towards MSB), 1 = moving right
    logic [1:0]       cur_mode_q, cur_mode_d;
    logic             running_q, running_d;
    logic             strobe_q, strobe_d;
    logic             tick, advance;
    logic [3:0]       sub_lim;
    logic [LED_W-1:0] seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_q  <= 2'b00;
            mode_s_q   <= 2'b00;
            run_s1_q   <= 1'b0;
            run_s_q    <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_cnt_q  <= '0;
            step_req_q <= 1'b0;
            state_q    <= PAUSE;
            cnt_q      <= '0;
            sub_q      <= '0;
            led_q      <= LED_W'(1);
            dir_q      <= 1'b0;
            cur_mode_q <= 2'b00;
            running_q  <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            mode_s1_q  <= mode;
            mode_s_q   <= mode_s1_q;
            run_s1_q   <= run;
            run_s_q    <= run_s1_q;
            btn_s1_q   <= step_btn;
            btn_s_q    <= btn_s1_q;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            step_req_q <= step_req_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            led_q      <= led_d;
            dir_q      <= dir_d;
            cur_mode_q <= cur_mode_d;
            running_q  <= running_d;
            strobe_q   <= strobe_d;
        end
    end

    // Any reversal before the count completes drops the count back to zero.
    always_comb begin
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        step_req_d = 1'b0;
        if (btn_s_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d      = btn_s_q;
                step_req_d = btn_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        seed = '0;
        case (mode_s_q)
            2'b00:   seed = LED_W'(1);
            2'b01:   seed = {1'b1, {(LED_W-1){1'b0}}};
            2'b10:   seed = LED_W'(1);
            default: seed = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sub_d      = sub_q;
        led_d      = led_q;
        dir_d      = dir_q;
        cur_mode_d = cur_mode_q;
        advance    = 1'b0;
        tick       = (state_q == RUN) && (cnt_q == CNT_LAST);
        sub_lim    = (4'd1 << speed) - 4'd1;

        case (state_q)
            PAUSE:   if (run_s_q)  state_d = RUN;
            default: if (!run_s_q) state_d = PAUSE;
        endcase

        if (state_q == RUN) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                // >= lets a mid-count speed reduction take effect on the next tick.
                if ({1'b0, sub_q} >= sub_lim) begin
                    sub_d   = '0;
                    advance = 1'b1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
        end else begin
            advance = step_req_q;
        end

        if (state_d == PAUSE) begin
            cnt_d = '0;
            sub_d = '0;
        end

        if (mode_s_q != cur_mode_q) begin
            cur_mode_d = mode_s_q;
            dir_d      = 1'b0;
            cnt_d      = '0;
            sub_d      = '0;
            led_d      = seed;
            advance    = 1'b0;
        end else if (advance) begin
            case (cur_mode_q)
                2'b00: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                2'b01: led_d = {led_q[0], led_q[LED_W-1:1]};
                2'b10: begin
                    if (!dir_q) begin
                        led_d = led_q << 1;
                        if (led_q[LED_W-2]) dir_d = 1'b1;
                    end else begin
                        led_d = led_q >> 1;
                        if (led_q[1]) dir_d = 1'b0;
                    end
                end
                default: led_d = ~led_q;
            endcase
        end

        strobe_d  = advance;
        running_d = (state_d == RUN);
    end

    assign led         = led_q;
    assign cur_mode    = cur_mode_q;
    assign running     = running_q;
    assign step_strobe = strobe_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - scoreboard bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        run = 1'b0;
    logic [1:0]  speed = 2'b00;
    logic        step_btn = 1'b0;
    logic [15:0] led;
    logic [1:0]  cur_mode;
    logic        running;
    logic        step_strobe;

    led_pattern_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3), .LED_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .run(run), .speed(speed),
        .step_btn(step_btn), .led(led), .cur_mode(cur_mode),
        .running(running), .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] led;
        int          gap;   // required cycles since previous step, 0 = unchecked
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = -1;
    bit   sb_en = 1'b0;
    exp_t e;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && sb_en && step_strobe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step: led=%h, no step was expected", led);
            end else begin
                e = sb.pop_front();
                if (led !== e.led) begin
                    errors++;
                    $display("FAIL step_led: led=%h expected %h", led, e.led);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_cyc != e.gap) begin
                        errors++;
                        $display("FAIL step_gap: gap=%0d expected %0d (led %h)", cyc - last_cyc, e.gap, e.led);
                    end
                end
            end
            last_cyc = cyc;
        end
    end

    task automatic push_exp(input logic [15:0] l, input int gap);
        exp_t x;
        x.led = l;
        x.gap = gap;
        sb.push_back(x);
    endtask

    task automatic do_reset(input logic [1:0] m, input logic r, input logic [1:0] s);
        sb_en = 1'b0;
        sb.delete();
        rst_n = 1'b0;
        mode = m;
        run = r;
        speed = s;
        step_btn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_cyc = -1;
        sb_en = 1'b1;
    endtask

    task automatic wait_sb(input int left, input int max_cyc, input string name);
        int n = 0;
        while (sb.size() > left && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() > left) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d steps outstanding, expected at most %0d", name, sb.size(), left);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #13;
        checks += 4;
        if (led !== 16'h0001) begin errors++; $display("FAIL reset_led: %h expected 0001", led); end
        if (cur_mode !== 2'b00) begin errors++; $display("FAIL reset_mode: %b expected 00", cur_mode); end
        if (running !== 1'b0) begin errors++; $display("FAIL reset_running: %b expected 0", running); end
        if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: %b expected 0", step_strobe); end
    endtask

    task automatic test_rotate_left;
        do_reset(2'b00, 1'b1, 2'd0);
        for (int p = 1; p <= 17; p++) push_exp(16'h0001 << (p % 16), (p == 1) ? 0 : 4);
        wait_sb(0, 120, "rotate_left");
        sb_en = 1'b0;
    endtask

    task automatic test_bounce;
        int k;
        do_reset(2'b10, 1'b1, 2'd0);
        for (int p = 1; p <= 32; p++) begin
            k = p % 30;
            push_exp(16'h0001 << ((k <= 15) ? k : 30 - k), (p == 1) ? 0 : 4);
        end
        wait_sb(0, 200, "bounce");
        sb_en = 1'b0;
    endtask

    task automatic test_speed_change;
        do_reset(2'b00, 1'b1, 2'd3);
        push_exp(16'h0002, 0);
        push_exp(16'h0004, 32);
        push_exp(16'h0008, 24);
        push_exp(16'h0010, 4);
        wait_sb(2, 120, "speed_slow");
        repeat (20) @(posedge clk);
        #1 speed = 2'd0;
        wait_sb(0, 80, "speed_fast");
        sb_en = 1'b0;
    endtask

    task automatic test_button;
        do_reset(2'b00, 1'b0, 2'd0);
        repeat (6) @(posedge clk);
        #1 step_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1 step_btn = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (led !== 16'h0001) begin errors++; $display("FAIL glitch_step: led=%h expected 0001", led); end
        push_exp(16'h0002, 0);
        step_btn = 1'b1;
        repeat (6) @(posedge clk);
        #1 step_btn = 1'b0;
        wait_sb(0, 40, "button_press");
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (led !== 16'h0002) begin errors++; $display("FAIL single_press: led=%h expected 0002", led); end
        speed = 2'd3;
        push_exp(16'h0004, 0);
        run = 1'b1;
        step_btn = 1'b1;
        repeat (6) @(posedge clk);
        #1 step_btn = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (led !== 16'h0002) begin errors++; $display("FAIL press_in_run: led=%h expected 0002", led); end
        wait_sb(0, 60, "run_after_press");
        sb_en = 1'b0;
    endtask

    task automatic test_mode_on_tick;
        do_reset(2'b00, 1'b1, 2'd0);
        push_exp(16'h0002, 0);
        wait_sb(0, 40, "mode_first");
        @(posedge clk);
        #1 mode = 2'b01;
        push_exp(16'h4000, 8);
        push_exp(16'h2000, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (led !== 16'h8000) begin errors++; $display("FAIL mode_seed: led=%h expected 8000", led); end
        if (step_strobe !== 1'b0) begin errors++; $display("FAIL mode_strobe: %b expected 0", step_strobe); end
        if (cur_mode !== 2'b01) begin errors++; $display("FAIL mode_cur: %b expected 01", cur_mode); end
        wait_sb(0, 40, "mode_after");
        sb_en = 1'b0;
    endtask

    task automatic test_async_reset;
        bit seen = 1'b0;
        do_reset(2'b00, 1'b1, 2'd0);
        push_exp(16'h0002, 0);
        push_exp(16'h0004, 4);
        wait_sb(0, 40, "pre_reset");
        @(posedge clk);
        #3;
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (led !== 16'h0001) begin errors++; $display("FAIL async_led: led=%h expected 0001", led); end
        if (running !== 1'b0) begin errors++; $display("FAIL async_running: %b expected 0", running); end
        if (step_strobe !== 1'b0) begin errors++; $display("FAIL async_strobe: %b expected 0", step_strobe); end
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (running === 1'b1) seen = 1'b1;
        end
        checks += 2;
        if (!seen) begin errors++; $display("FAIL resume_running: running=%b, expected 1 within 3 cycles", running); end
        if (led !== 16'h0001) begin errors++; $display("FAIL resume_led: led=%h expected 0001", led); end
    endtask

    initial begin
        test_reset;
        test_rotate_left;
        test_bounce;
        test_speed_change;
        test_button;
        test_mode_on_tick;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
